uart_tx_cfg: RTL and testbench

- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises one frame per handshake. Data width is a parameter; parity mode and stop-bit count are selected per frame at run time.
- Drives the line from the system clock domain. Feeds the board TX pin or the loopback path of the UART receiver.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_cfg.sv | 158 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of each CLK_PER_BIT period.
module uart_baud_tick #(
  parameter int CLK_PER_BIT = 87,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with parametrised data width and per-frame parity / stop-bit selection.
// Optional line-break request port enabled by defining UART_TX_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 87,
  parameter int DATA_BITS   = 8,
  parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  input  logic [1:0]           i_parity_mode,
  input  logic                 i_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_tx_break,
`endif
  output logic                 o_tx_ready,
  output logic                 o_tx_active,
  output logic                 o_tx_serial,
  output logic                 o_tx_done
);

  if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
    $error("uart_tx_cfg: CLK_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end

  localparam int              IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] data_q;
  logic [1:0]           mode_q;
  logic                 two_q;
  logic                 load;
  logic                 tick;
  logic                 brk;
  logic                 brk_idle;
  logic                 par_bit;
  logic                 serial_n, ready_n, active_n, done_n;

`ifdef UART_TX_BREAK_EN
  assign brk = i_tx_break;
`else
  assign brk = 1'b0;
`endif

  // Break only takes hold once the FSM is already idle, so the done cycle still reports ready.
  assign brk_idle = brk && (state == IDLE);
  assign par_bit  = (^data_q) ^ (mode_q == PAR_ODD);

  uart_baud_tick #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    stop_n  = stop_cnt;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (i_tx_dv && !brk) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            state_n = parity_enabled(mode_q) ? PARITY : STOP;
            stop_n  = 1'b0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == two_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line and status outputs are registered from the next state.
    serial_n = 1'b1;
    case (state_n)
      IDLE:    serial_n = ~brk_idle;
      START:   serial_n = 1'b0;
      DATA:    serial_n = data_q[idx_n];
      PARITY:  serial_n = par_bit;
      STOP:    serial_n = 1'b1;
      default: serial_n = 1'b1;
    endcase
    ready_n  = (state_n == IDLE) && !brk_idle;
    active_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      stop_cnt    <= 1'b0;
      data_q      <= '0;
      mode_q      <= PAR_NONE;
      two_q       <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_ready  <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      stop_cnt    <= stop_n;
      o_tx_serial <= serial_n;
      o_tx_ready  <= ready_n;
      o_tx_active <= active_n;
      o_tx_done   <= done_n;
      if (load) begin
        data_q <= i_tx_byte;
        mode_q <= i_parity_mode;
        two_q  <= i_two_stop;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (8-bit and 5-bit instances, CLK_PER_BIT=4).
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       dv8 = 1'b0, two8 = 1'b0;
  logic [7:0] byte8 = '0;
  logic [1:0] mode8 = 2'b00;
  logic       ready8, active8, ser8, done8;

  logic       dv5 = 1'b0, two5 = 1'b0;
  logic [4:0] byte5 = '0;
  logic [1:0] mode5 = 2'b00;
  logic       ready5, active5, ser5, done5;

`ifdef UART_TX_BREAK_EN
  logic brk8 = 1'b0;
  logic brk5 = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .i_tx_dv       (dv8),
    .i_tx_byte     (byte8),
    .i_parity_mode (mode8),
    .i_two_stop    (two8),
`ifdef UART_TX_BREAK_EN
    .i_tx_break    (brk8),
`endif
    .o_tx_ready    (ready8),
    .o_tx_active   (active8),
    .o_tx_serial   (ser8),
    .o_tx_done     (done8)
  );

  uart_tx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(5)) dut5 (
    .clk           (clk),
    .rst           (rst),
    .i_tx_dv       (dv5),
    .i_tx_byte     (byte5),
    .i_parity_mode (mode5),
    .i_two_stop    (two5),
`ifdef UART_TX_BREAK_EN
    .i_tx_break    (brk5),
`endif
    .o_tx_ready    (ready5),
    .o_tx_active   (active5),
    .o_tx_serial   (ser5),
    .o_tx_done     (done5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ser_of(input int w);
    return (w == 8) ? ser8 : ser5;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 8) ? ready8 : ready5;
  endfunction
  function automatic logic active_of(input int w);
    return (w == 8) ? active8 : active5;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done5;
  endfunction

  task automatic drive(input int w, input logic dv, input logic [8:0] data,
                       input logic [1:0] mode, input logic two);
    if (w == 8) begin
      dv8 = dv; byte8 = data[7:0]; mode8 = mode; two8 = two;
    end else begin
      dv5 = dv; byte5 = data[4:0]; mode5 = mode; two5 = two;
    end
  endtask

  task automatic set_dv(input int w, input logic dv);
    if (w == 8) dv8 = dv;
    else        dv5 = dv;
  endtask

  // One frame: inputs are scrambled right after acceptance and a stray request is
  // raised mid-frame; exp_bits[i] is the expected level of frame bit i.
  task automatic run_frame(input int w, input logic [8:0] data, input logic [1:0] mode,
                           input logic two, input int nbits, input logic [15:0] exp_bits,
                           input string tag);
    logic s [0:63];
    int   flen, done_at, done_cnt, act_bad, tail_bad;
    flen     = nbits * 4;
    done_at  = -1;
    done_cnt = 0;
    act_bad  = 0;
    tail_bad = 0;
    @(negedge clk);
    check({tag, "_ready_pre"}, 32'(ready_of(w)), 32'd1);
    drive(w, 1'b1, data, mode, two);
    @(posedge clk);
    #1 drive(w, 1'b0, ~data, ~mode, ~two);
    for (int k = 0; k < flen + 4; k++) begin
      @(negedge clk);
      s[k] = ser_of(w);
      if (done_of(w)) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < flen && !active_of(w)) act_bad++;
      if (k > flen && !s[k]) tail_bad++;
      if (k == flen) begin
        check({tag, "_ready_done"}, 32'(ready_of(w)), 32'd1);
        check({tag, "_active_done"}, 32'(active_of(w)), 32'd0);
      end
      if (k == 6) set_dv(w, 1'b1);
      if (k == 7) set_dv(w, 1'b0);
    end
    for (int b = 0; b < nbits; b++) begin
      check($sformatf("%s_bit%0d", tag, b), 32'({s[4*b], s[4*b+3]}),
            32'({exp_bits[b], exp_bits[b]}));
    end
    check({tag, "_done_at"}, 32'(done_at), 32'(flen));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_active"}, 32'(act_bad), 32'd0);
    check({tag, "_tail_idle"}, 32'(tail_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic s2 [0:95];
    int   d0, d1, nd, bad_line, bad_ready, bad_act;

    #12;
    check("rst_serial", 32'(ser8), 32'd1);
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_active", 32'(active8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(8, 9'h0A5, 2'b00, 1'b0, 10, 16'h034A, "a5_none");
    run_frame(8, 9'h0A5, 2'b01, 1'b0, 11, 16'h054A, "a5_even");
    run_frame(8, 9'h0A5, 2'b10, 1'b0, 11, 16'h074A, "a5_odd");
    run_frame(5, 9'h013, 2'b10, 1'b1, 9,  16'h01A6, "d5_odd_2stop");
    run_frame(8, 9'h0A5, 2'b11, 1'b0, 10, 16'h034A, "a5_mode3");

    // Back-to-back with i_tx_dv held high: 8'h00 then 8'hFF.
    @(negedge clk);
    drive(8, 1'b1, 9'h000, 2'b00, 1'b0);
    @(posedge clk);
    d0 = -1; d1 = -1; nd = 0;
    for (int k = 0; k < 85; k++) begin
      @(negedge clk);
      s2[k] = ser8;
      if (done8) begin
        nd++;
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
      end
      if (k == 5) byte8 = 8'hFF;
      if (k == 41) dv8 = 1'b0;
    end
    for (int b = 0; b < 10; b++) begin
      check($sformatf("b2b_f1_bit%0d", b), 32'({s2[4*b], s2[4*b+3]}), (b == 9) ? 32'd3 : 32'd0);
      check($sformatf("b2b_f2_bit%0d", b), 32'({s2[41+4*b], s2[44+4*b]}), (b == 0) ? 32'd0 : 32'd3);
    end
    check("b2b_gap", 32'(s2[40]), 32'd1);
    check("b2b_done0", 32'(d0), 32'd40);
    check("b2b_done1", 32'(d1), 32'd81);
    check("b2b_done_cnt", 32'(nd), 32'd2);
    check("b2b_tail", 32'({s2[82], s2[83], s2[84]}), 32'd7);

    // Asynchronous reset ten cycles into a frame.
    @(negedge clk);
    drive(8, 1'b1, 9'h000, 2'b00, 1'b0);
    @(posedge clk);
    #1 dv8 = 1'b0;
    for (int k = 0; k <= 10; k++) @(negedge clk);
    check("mid_rst_pre_line", 32'(ser8), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_serial", 32'(ser8), 32'd1);
    check("mid_rst_active", 32'(active8), 32'd0);
    check("mid_rst_ready", 32'(ready8), 32'd1);
    check("mid_rst_done", 32'(done8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done8 || active8 || !ser8) nd++;
    end
    check("post_rst_quiet", 32'(nd), 32'd0);
    run_frame(8, 9'h0A5, 2'b00, 1'b0, 10, 16'h034A, "post_rst");

`ifdef UART_TX_BREAK_EN
    @(negedge clk);
    brk8 = 1'b1;
    drive(8, 1'b1, 9'h03C, 2'b00, 1'b0);
    bad_line = 0; bad_ready = 0; bad_act = 0;
    repeat (20) begin
      @(negedge clk);
      if (ser8) bad_line++;
      if (ready8) bad_ready++;
      if (active8) bad_act++;
    end
    check("brk_line_low", 32'(bad_line), 32'd0);
    check("brk_ready_low", 32'(bad_ready), 32'd0);
    check("brk_no_accept", 32'(bad_act), 32'd0);
    brk8 = 1'b0;
    dv8  = 1'b0;
    @(negedge clk);
    check("brk_release_line", 32'(ser8), 32'd1);
    check("brk_release_ready", 32'(ready8), 32'd1);
    run_frame(8, 9'h0A5, 2'b00, 1'b0, 10, 16'h034A, "post_brk");
`else
    bad_line = 0; bad_ready = 0; bad_act = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
